// File: rtl/pingpong_sram_buffer.sv
// Ping-pong SRAM buffer: the producer fills one bank while the consumer drains
// the other. Each bank is a single-port array with a registered Q. Read data is
// staged through an output register plus one skid entry, and reads are issued
// only when there is room to land them.
module pingpong_sram_buffer #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_last,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_last,
  output logic [1:0]       bank_full
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {EMPTY, FULL, DRAIN} bank_st_e;

  bank_st_e         state [2];
  logic [AW:0]      len   [2];
  logic             wsel, rsel, isel;  // write bank, retire bank, read-issue bank
  logic [AW-1:0]    waddr, raddr;
  logic             issuing;           // isel bank has words issued, more to go

  // Q stage: one read in flight out of the selected bank
  logic             q_vld, q_last, q_sel;
  logic [WIDTH-1:0] q_data;

  // output register and skid entry
  logic             out_v, out_last, skid_v, skid_last;
  logic [WIDTH-1:0] out_data, skid_data;

  logic             wr_acc, wr_close;
  logic             rd_pop, can_issue, rd_issue, rd_start, issue_last, retire;
  logic [1:0]       occ;

  assign wr_ready  = (state[wsel] == EMPTY);
  assign wr_acc    = wr_valid & wr_ready;
  assign wr_close  = wr_acc & ((waddr == AW'(DEPTH-1)) | wr_last);

  // A read lands two edges after issue; allow it only if the output register
  // and skid entry are guaranteed to have room for it by then.
  assign occ        = 2'(q_vld) + 2'(out_v) + 2'(skid_v);
  assign rd_pop     = out_v & rd_ready;
  assign can_issue  = (occ < 2'd2) | ((occ == 2'd2) & rd_pop);
  assign rd_issue   = can_issue & (issuing | (state[isel] == FULL));
  assign rd_start   = rd_issue & ~issuing;
  assign issue_last = ({1'b0, raddr} == (len[isel] - (AW+1)'(1)));
  assign retire     = out_v & rd_ready & out_last;

  assign rd_valid  = out_v;
  assign rd_data   = out_data;
  assign rd_last   = out_last;
  assign bank_full = {state[1] != EMPTY, state[0] != EMPTY};

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] q;
    logic             cen_n, wen_n;
    logic [AW-1:0]    addr;
    logic             wr_en, rd_en;

    assign wr_en = wr_acc & (wsel == 1'(b));
    assign rd_en = rd_issue & (isel == 1'(b));
    assign cen_n = ~(wr_en | rd_en);
    assign wen_n = ~wr_en;
    assign addr  = wr_en ? waddr : raddr;

    // single-port array: write, or registered read, when selected
    always_ff @(posedge CLK) begin
      if (!cen_n) begin
        if (!wen_n) mem[addr] <= wr_data;
        else        q         <= mem[addr];
      end
    end
  end

  assign q_data = q_sel ? g_bank[1].q : g_bank[0].q;

  // bank states, pointers, lengths and the read-issue pipeline
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wsel    <= 1'b0;
      rsel    <= 1'b0;
      isel    <= 1'b0;
      waddr   <= '0;
      raddr   <= '0;
      issuing <= 1'b0;
      q_vld   <= 1'b0;
      q_last  <= 1'b0;
      q_sel   <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        state[b] <= EMPTY;
        len[b]   <= '0;
      end
    end else begin
      q_vld  <= rd_issue;
      q_last <= issue_last;
      q_sel  <= isel;
      if (wr_acc) begin
        if (wr_close) begin
          waddr <= '0;
          wsel  <= ~wsel;
        end else begin
          waddr <= waddr + AW'(1);
        end
      end
      if (rd_issue) begin
        if (issue_last) begin
          raddr   <= '0;
          isel    <= ~isel;
          issuing <= 1'b0;
        end else begin
          raddr   <= raddr + AW'(1);
          issuing <= 1'b1;
        end
      end
      if (retire) rsel <= ~rsel;
      // close, drain start and drain complete always act on different banks
      for (int b = 0; b < 2; b++) begin
        if (wr_close && wsel == 1'(b)) begin
          state[b] <= FULL;
          len[b]   <= {1'b0, waddr} + (AW+1)'(1);
        end else if (rd_start && isel == 1'(b)) begin
          state[b] <= DRAIN;
        end else if (retire && rsel == 1'(b)) begin
          state[b] <= EMPTY;
        end
      end
    end
  end

  // output register with one skid entry; skid always holds the older word
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      out_v     <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      skid_v    <= 1'b0;
      skid_last <= 1'b0;
      skid_data <= '0;
    end else if (q_vld) begin
      if (!out_v || rd_pop) begin
        out_v <= 1'b1;
        if (skid_v) begin
          out_data  <= skid_data;
          out_last  <= skid_last;
          skid_data <= q_data;
          skid_last <= q_last;
        end else begin
          out_data <= q_data;
          out_last <= q_last;
        end
      end else begin
        skid_v    <= 1'b1;
        skid_data <= q_data;
        skid_last <= q_last;
      end
    end else if (!out_v || rd_pop) begin
      out_v  <= skid_v;
      skid_v <= 1'b0;
      if (skid_v) begin
        out_data <= skid_data;
        out_last <= skid_last;
      end else begin
        out_last <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pingpong_sram_buffer.sv
// Bench for pingpong_sram_buffer: directed scenarios plus a frame-level
// scoreboard that tracks accepted words, frame boundaries and bank occupancy.
module tb_pingpong_sram_buffer;
  localparam int W = 64;
  localparam int D = 8;

  logic         CLK      = 1'b0;
  logic         RSTN     = 1'b1;
  logic         wr_valid = 1'b0;
  logic         wr_ready;
  logic [W-1:0] wr_data  = '0;
  logic         wr_last  = 1'b0;
  logic         rd_valid;
  logic         rd_ready = 1'b0;
  logic [W-1:0] rd_data;
  logic         rd_last;
  logic [1:0]   bank_full;

  pingpong_sram_buffer #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .bank_full(bank_full)
  );

  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model: queue of expected words; frames closed / retired since reset
  typedef struct packed {logic [W-1:0] d; logic last;} ent_t;
  ent_t         exp_q[$];
  int           closed, retired, pos;
  bit           prev_stall;
  logic [W-1:0] prev_data;
  logic         prev_last;

  // frame k (counted from reset) lives in bank k%2; at most two frames held
  function automatic logic [1:0] exp_bf();
    int n = closed - retired;
    if (n == 0) return 2'b00;
    if (n == 1) return (retired % 2 == 0) ? 2'b01 : 2'b10;
    return 2'b11;
  endfunction

  // model update on each edge
  always @(posedge CLK or negedge RSTN) begin : model
    logic l;
    if (!RSTN) begin
      exp_q.delete();
      closed = 0; retired = 0; pos = 0; prev_stall = 0;
    end else begin
      if (wr_valid && wr_ready) begin
        l = wr_last || (pos == D-1);
        exp_q.push_back('{d: wr_data, last: l});
        pos = l ? 0 : pos + 1;
        if (l) closed++;
      end
      if (rd_valid && rd_ready && exp_q.size() > 0) begin
        if (exp_q[0].last) retired++;
        void'(exp_q.pop_front());
      end
      prev_stall = rd_valid && !rd_ready;
      prev_data  = rd_data;
      prev_last  = rd_last;
    end
  end

  // scoreboard checks mid-cycle
  always @(negedge CLK) begin
    if (RSTN) begin
      n_cmp++;
      if (wr_ready !== ((closed - retired) < 2)) begin
        n_fail++; $display("FAIL sb_wr_ready: got %0b want %0b", wr_ready, (closed - retired) < 2);
      end
      n_cmp++;
      if (bank_full !== exp_bf()) begin
        n_fail++; $display("FAIL sb_bank_full: got %0b want %0b", bank_full, exp_bf());
      end
      if (closed == retired) begin
        n_cmp++;
        if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL sb_idle_valid: got %0b want 0", rd_valid); end
      end
      if (prev_stall) begin
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_data !== prev_data || rd_last !== prev_last) begin
          n_fail++; $display("FAIL sb_stall_stable: got %0b/%0h/%0b want 1/%0h/%0b",
                             rd_valid, rd_data, rd_last, prev_data, prev_last);
        end
      end
      if (rd_valid && rd_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL sb_extra_word: got %0h want none", rd_data);
        end else if (rd_data !== exp_q[0].d || rd_last !== exp_q[0].last) begin
          n_fail++; $display("FAIL sb_word: got %0h/%0b want %0h/%0b", rd_data, rd_last, exp_q[0].d, exp_q[0].last);
        end
      end
    end
  end

  task automatic write_word(input logic [W-1:0] d, input logic last);
    int t = 0;
    wr_valid = 1'b1; wr_data = d; wr_last = last;
    do begin @(posedge CLK); t++; end while (!wr_ready && t < 300);
    #1;
    wr_valid = 1'b0; wr_last = 1'b0;
    if (t >= 300) begin n_cmp++; n_fail++; $display("FAIL write_timeout: got stuck want accept"); end
  endtask

  task automatic do_reset();
    wr_valid = 1'b0; wr_last = 1'b0; RSTN = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RSTN = 1'b1;
  endtask

  task automatic test_reset();
    #2 RSTN = 1'b0;
    #2;
    n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rd_valid: got %0b want 0", rd_valid); end
    n_cmp++; if (rd_last !== 1'b0) begin n_fail++; $display("FAIL rst_rd_last: got %0b want 0", rd_last); end
    n_cmp++; if (rd_data !== '0) begin n_fail++; $display("FAIL rst_rd_data: got %0h want 0", rd_data); end
    n_cmp++; if (bank_full !== 2'b00) begin n_fail++; $display("FAIL rst_bank_full: got %0b want 00", bank_full); end
    @(posedge CLK); #1 RSTN = 1'b1; #1;
    n_cmp++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_wr_ready: got %0b want 1", wr_ready); end
  endtask

  task automatic test_full_bank();
    logic [W-1:0] w;
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) write_word(64'h10 + 64'(i), 1'b0);
    n_cmp++; if (bank_full !== 2'b01) begin n_fail++; $display("FAIL fb_bank_full: got %0b want 01", bank_full); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL fb_lat_e0: got %0b want 0", rd_valid); end
    @(posedge CLK); #1;
    n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL fb_lat_e1: got %0b want 0", rd_valid); end
    @(posedge CLK); #1;
    for (int k = 0; k < 8; k++) begin
      w = 64'h10 + 64'(k);
      n_cmp++;
      if (rd_valid !== 1'b1 || rd_data !== w || rd_last !== (k == 7)) begin
        n_fail++; $display("FAIL fb_word%0d: got %0b/%0h/%0b want 1/%0h/%0b", k, rd_valid, rd_data, rd_last, w, k == 7);
      end
      @(posedge CLK); #1;
    end
    n_cmp++; if (bank_full !== 2'b00) begin n_fail++; $display("FAIL fb_bank_empty: got %0b want 00", bank_full); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL fb_done_valid: got %0b want 0", rd_valid); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w;
    rd_ready = 1'b0;
    for (int i = 0; i < 16; i++) write_word(64'h100 + 64'(i), 1'b0);
    n_cmp++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_wr_ready: got %0b want 0", wr_ready); end
    n_cmp++; if (bank_full !== 2'b11) begin n_fail++; $display("FAIL b2b_bank_full: got %0b want 11", bank_full); end
    repeat (3) @(posedge CLK);
    #1 rd_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      w = 64'h100 + 64'(k);
      n_cmp++;
      if (rd_valid !== 1'b1 || rd_data !== w || rd_last !== (k == 7 || k == 15)) begin
        n_fail++; $display("FAIL b2b_word%0d: got %0b/%0h/%0b want 1/%0h/%0b", k, rd_valid, rd_data, rd_last, w, k == 7 || k == 15);
      end
      @(posedge CLK); #1;
    end
    n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_done_valid: got %0b want 0", rd_valid); end
  endtask

  task automatic test_short_frame();
    int got = 0, last_at = 0;
    do_reset();
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) write_word(64'h50 + 64'(i), i == 2);
    for (int c = 0; c < 20; c++) begin
      @(posedge CLK);
      if (rd_valid && rd_ready) begin got++; if (rd_last) last_at = got; end
    end
    #1;
    n_cmp++; if (got !== 3) begin n_fail++; $display("FAIL sf_count: got %0d want 3", got); end
    n_cmp++; if (last_at !== 3) begin n_fail++; $display("FAIL sf_last_pos: got %0d want 3", last_at); end
    rd_ready = 1'b0;
    write_word(64'hABC, 1'b1);
    n_cmp++; if (bank_full !== 2'b10) begin n_fail++; $display("FAIL sf_next_bank: got %0b want 10", bank_full); end
    rd_ready = 1'b1;
    repeat (8) @(posedge CLK);
    #1;
  endtask

  task automatic test_random();
    int lens[10];
    int total = 0, got = 0;
    for (int f = 0; f < 10; f++) begin lens[f] = $urandom_range(1, 8); total += lens[f]; end
    fork
      begin
        for (int f = 0; f < 10; f++)
          for (int i = 0; i < lens[f]; i++) begin
            if ($urandom_range(0, 3) == 0) begin @(posedge CLK); #1; end
            write_word({$urandom, $urandom}, i == lens[f] - 1);
          end
      end
      begin
        for (int c = 0; c < 3000 && got < total; c++) begin
          rd_ready = $urandom_range(0, 1);
          @(posedge CLK);
          if (rd_valid && rd_ready) got++;
          #1;
        end
      end
    join
    rd_ready = 1'b0;
    n_cmp++; if (got !== total) begin n_fail++; $display("FAIL rnd_count: got %0d want %0d", got, total); end
  endtask

  task automatic test_stream();
    int got = 0, low = 0, max_low = 0, gap = 0, max_gap = 0;
    bit wdone = 0, started = 0;
    rd_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 40; i++) write_word(64'h1000 + 64'(i), 1'b0);
        wdone = 1;
      end
      begin
        for (int c = 0; c < 400 && got < 40; c++) begin
          @(posedge CLK);
          if (rd_valid && rd_ready) got++;
          #1;
          if (!wr_ready && !wdone) low++; else low = 0;
          if (low > max_low) max_low = low;
          if (rd_valid) begin started = 1; gap = 0; end
          else if (started && got < 40) gap++;
          if (gap > max_gap) max_gap = gap;
        end
      end
    join
    n_cmp++; if (got !== 40) begin n_fail++; $display("FAIL st_count: got %0d want 40", got); end
    n_cmp++; if (max_low > 2) begin n_fail++; $display("FAIL st_wr_stall: got %0d want <=2", max_low); end
    n_cmp++; if (max_gap > 2) begin n_fail++; $display("FAIL st_rd_gap: got %0d want <=2", max_gap); end
  endtask

  task automatic test_reset_mid_drain();
    int got = 0;
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) write_word(64'h200 + 64'(i), 1'b0);
    for (int c = 0; c < 50 && got < 4; c++) begin
      @(posedge CLK);
      if (rd_valid && rd_ready) got++;
    end
    n_cmp++; if (got !== 4) begin n_fail++; $display("FAIL rm_partial: got %0d want 4", got); end
    #1 RSTN = 1'b0;
    #1;
    n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rm_rd_valid: got %0b want 0", rd_valid); end
    n_cmp++; if (bank_full !== 2'b00) begin n_fail++; $display("FAIL rm_bank_full: got %0b want 00", bank_full); end
    @(posedge CLK); #1 RSTN = 1'b1; #1;
    n_cmp++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL rm_wr_ready: got %0b want 1", wr_ready); end
    got = 0;
    for (int i = 0; i < 5; i++) write_word(64'h300 + 64'(i), i == 4);
    for (int c = 0; c < 20; c++) begin
      @(posedge CLK);
      if (rd_valid && rd_ready) got++;
    end
    #1;
    n_cmp++; if (got !== 5) begin n_fail++; $display("FAIL rm_new_frame: got %0d want 5", got); end
  endtask

  initial begin
    test_reset();
    test_full_bank();
    test_back_to_back();
    test_short_frame();
    test_random();
    test_stream();
    test_reset_mid_drain();
    rd_ready = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
